par_serial_tx: RTL and testbench

Parallel-to-serial transmitter sitting directly downstream of the two-lane byte multiplexer in the PHY transmit path. Accepts the multiplexed 8-bit byte stream with its valid flag and shifts each byte out MSB-first, one bit per `clk_8f` cycle. Sends a comma/idle byte whenever no valid data is offered, and optionally sends a comma-only training burst after reset so the receiver can align.

---
 rtl/par_serial_tx.sv | 113 +++++++++++
 tb/tb_par_serial_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/par_serial_tx.sv
// par_serial_tx: serialises the multiplexed byte stream MSB-first at one bit
// per clk_8f cycle. A comma (IDLE_BYTE) is sent whenever no valid byte is
// offered on a load edge.
// Optional feature macro P2S_SYNC_EN: when defined, a comma-only training
// burst of SYNC_COMMAS bytes is sent after reset before inputs are accepted.
// When undefined, the transmitter is active straight out of reset.
module par_serial_tx #(
`ifdef P2S_SYNC_EN
   parameter int unsigned SYNC_COMMAS = 4,
`endif
   parameter logic [7:0]  IDLE_BYTE   = 8'hBC
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       active_out,
   output logic       data_out
);

   logic [2:0] bit_cnt;
   logic [7:0] cur_byte;
   logic [7:0] next_byte;
   logic       load_edge;
   logic [7:0] fresh_byte;

   // The last bit of the current byte goes out on the same edge the next byte is loaded.
   assign load_edge  = (bit_cnt == 3'd7);
   // An invalid upstream byte becomes a comma on the line.
   assign fresh_byte = valid_in ? data_in : IDLE_BYTE;

`ifdef P2S_SYNC_EN
   typedef enum logic {
      SYNC,
      ACTIVE
   } state_t;

   localparam logic [3:0] LAST_COMMA = 4'(SYNC_COMMAS - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] comma_cnt;
   logic [3:0] next_comma_cnt;
   logic       last_comma;

   assign last_comma = (comma_cnt == LAST_COMMA);

   // Training state and comma counter registers.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state     <= SYNC;
         comma_cnt <= 4'd0;
      end else begin
         state     <= next_state;
         comma_cnt <= next_comma_cnt;
      end
   end

   // Next-state and byte-load decode; inputs are ignored until the last comma loads.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      next_state     = state;
      next_comma_cnt = comma_cnt;
      next_byte      = cur_byte;
      if (load_edge) begin
         case (state)
            SYNC: begin
               if (last_comma) begin
                  next_state = ACTIVE;
                  next_byte  = fresh_byte;
               end else begin
                  next_byte      = IDLE_BYTE;
                  next_comma_cnt = comma_cnt + 4'd1;
               end
            end
            ACTIVE:  next_byte = fresh_byte;
            default: next_state = SYNC;
         endcase
      end
   end

   assign ready_out  = load_edge && ((state == ACTIVE) || last_comma);
   assign active_out = (state == ACTIVE);
`else
   // Without training every load edge accepts the upstream byte.
   always_comb begin
      next_byte = cur_byte;
      if (load_edge) begin
         next_byte = fresh_byte;
      end
   end

   assign ready_out  = load_edge;
   // Always active whenever reset is released.
   assign active_out = reset;
`endif

   // Bit counter, shift byte and registered serial output.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         bit_cnt  <= 3'd0;
         cur_byte <= IDLE_BYTE;
         data_out <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         data_out <= cur_byte[3'd7 - bit_cnt];
         bit_cnt  <= bit_cnt + 3'd1;
         cur_byte <= next_byte;
      end
   end

endmodule

// File: tb/tb_par_serial_tx.sv
// tb_par_serial_tx: directed bench for par_serial_tx. Expectations follow the
// build: with P2S_SYNC_EN four training commas precede the first ready_out,
// without it the first load edge ends the very first byte.
module tb_par_serial_tx;

   localparam logic [7:0] IDLE = 8'hBC;
`ifdef P2S_SYNC_EN
   localparam int TRAIN_FRAMES = 4;
   localparam int ACTIVE_FRAME = 4;
`else
   localparam int TRAIN_FRAMES = 1;
   localparam int ACTIVE_FRAME = 0;
`endif

   logic       clk_8f = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] data_in  = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic       active_out;
   logic       data_out;

   int checks = 0;
   int errors = 0;

   par_serial_tx dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .active_out (active_out),
      .data_out   (data_out)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_8f);
      #1;
   endtask

   // One byte period: checks the 8 emitted bits, ready_out mid-byte and at the
   // load cycle, active_out after the first edge. Junk with a toggling valid is
   // driven between load edges; the real inputs are presented in the ready cycle.
   task automatic frame(input string tag, input logic [7:0] exp_byte, input logic exp_ready,
                        input logic exp_active, input logic [7:0] drv_data, input logic drv_valid);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            data_in  = drv_data;
            valid_in = drv_valid;
            check({tag, "_ready"}, ready_out, exp_ready);
         end else begin
            data_in  = ~drv_data ^ 8'(i);
            valid_in = (i % 2) == 1;
         end
         if (i == 3) check({tag, "_ready_mid"}, ready_out, 1'b0);
         tick();
         check({tag, "_bit"}, data_out, exp_byte[7-i]);
         if (i == 0) check({tag, "_active"}, active_out, exp_active);
      end
   endtask

   // Training frames after a reset release; the last one offers first_data.
   task automatic train(input string tag, input logic [7:0] first_data);
      for (int k = 0; k < TRAIN_FRAMES; k++) begin
         if (k == TRAIN_FRAMES - 1)
            frame(tag, IDLE, 1'b1, k >= ACTIVE_FRAME, first_data, 1'b1);
         else
            frame(tag, IDLE, 1'b0, k >= ACTIVE_FRAME, 8'h00, 1'b0);
      end
   endtask

   logic [7:0] exp_bytes [5] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'hBC};
   logic [7:0] drv_bytes [5] = '{8'h00, 8'hFF, 8'h3C, 8'h55, 8'hE7};
   logic       drv_valid [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      // Reset state.
      tick();
      check("rst_data", data_out, 1'b0);
      check("rst_ready", ready_out, 1'b0);
      check("rst_active", active_out, 1'b0);
      reset = 1'b1;

      // Idle stream for 48 cycles: six commas, ready from the training end.
      for (int k = 0; k < 6; k++) begin
         frame("idle", IDLE, k >= TRAIN_FRAMES - 1, k >= ACTIVE_FRAME, 8'h55, 1'b0);
      end

      // Fresh reset, then data: A5, back-to-back 00/FF/3C, invalid 55 -> comma.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      train("train1", 8'hA5);
      for (int j = 0; j < 5; j++) begin
         frame("data", exp_bytes[j], 1'b1, 1'b1, drv_bytes[j], drv_valid[j]);
      end

      // Three bits of E7 go out, then reset lands at bit_cnt == 3.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("partial_bit", data_out, 1'b1);
      end
      reset = 1'b0;
      #1;
      check("midrst_data", data_out, 1'b0);
      check("midrst_active", active_out, 1'b0);
      check("midrst_ready", ready_out, 1'b0);
      tick();
      tick();
      check("held_rst_data", data_out, 1'b0);
      reset = 1'b1;

      // Training restarts from comma 1; the partial E7 never resumes.
      train("train2", 8'hC3);
      frame("after_rst", 8'hC3, 1'b1, 1'b1, 8'h81, 1'b1);
      frame("last", 8'h81, 1'b1, 1'b1, 8'h00, 1'b0);
      frame("tail", IDLE, 1'b1, 1'b1, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
